// File: rtl/muldiv_if.sv
// Request/response bundle between an issuing stage and the iterative multiply/divide unit.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] inputA;
    logic [WIDTH-1:0] inputB;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             negative;
    logic             zero;

    modport master (
        output in_valid, op, inputA, inputB, out_ready,
        input  in_ready, out_valid, result, negative, zero
    );

    modport slave (
        input  in_valid, op, inputA, inputB, out_ready,
        output in_ready, out_valid, result, negative, zero
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on operand
// magnitudes, one bit per cycle, with result and flags held until the consumer takes them.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic     clk,
    input logic     rst,
    input logic     flush,
    muldiv_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic [2:0]         op_r;
    logic               sa_r, sb_r;
    logic [2*WIDTH-1:0] acc, mc;
    logic [WIDTH-1:0]   mp;
    logic [WIDTH-1:0]   result_r;
    logic               negative_r, zero_r;

    logic               is_div, sa_in, sb_in, b_zero, ovf, special, accept;
    logic [WIDTH-1:0]   abs_a, abs_b, special_res, next_res;
    logic [WIDTH:0]     rem_sh, diff;
    logic [2*WIDTH-1:0] acc_nxt;

    // Undo the magnitude transform; divide keeps {remainder, quotient} in acc.
    function automatic logic [WIDTH-1:0] finish_result(input logic [2:0] o,
                                                       input logic [2*WIDTH-1:0] a,
                                                       input logic sa, input logic sb);
        logic [2*WIDTH-1:0] p;
        logic [WIDTH-1:0]   q, r, res;
        p = (sa ^ sb) ? -a : a;
        q = a[WIDTH-1:0];
        r = a[2*WIDTH-1:WIDTH];
        if (!o[2])
            res = (o == 3'd0) ? p[WIDTH-1:0] : p[2*WIDTH-1:WIDTH];
        else if (o[1])
            res = sa ? -r : r;
        else
            res = (sa ^ sb) ? -q : q;
        return res;
    endfunction

    always_comb begin
        is_div = bus.op[2];
        sa_in  = 1'b0;
        sb_in  = 1'b0;
        unique case (bus.op)
            3'd0, 3'd1, 3'd4, 3'd6: begin
                sa_in = bus.inputA[WIDTH-1];
                sb_in = bus.inputB[WIDTH-1];
            end
            3'd2:    sa_in = bus.inputA[WIDTH-1];
            default: ;
        endcase
        abs_a       = sa_in ? -bus.inputA : bus.inputA;
        abs_b       = sb_in ? -bus.inputB : bus.inputB;
        b_zero      = (bus.inputB == '0);
        ovf         = is_div && !bus.op[0] && (bus.inputA == MIN_VAL) && (bus.inputB == '1);
        special     = is_div && (b_zero || ovf);
        special_res = bus.op[1] ? (b_zero ? bus.inputA : '0) : (b_zero ? '1 : MIN_VAL);
        accept      = (state == IDLE) && bus.in_valid && !flush;
    end

    // One iteration: restoring-divide step or conditional shift-add.
    always_comb begin
        rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff   = rem_sh - {1'b0, mp};
        if (op_r[2])
            acc_nxt = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                  : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            acc_nxt = mp[0] ? acc + mc : acc;
        next_res = (state == IDLE) ? special_res : finish_result(op_r, acc_nxt, sa_r, sb_r);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            result_r   <= '0;
            negative_r <= 1'b0;
            zero_r     <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE: if (bus.in_valid) begin
                    if (special) begin
                        state      <= DONE;
                        result_r   <= next_res;
                        negative_r <= next_res[WIDTH-1];
                        zero_r     <= (next_res == '0);
                    end else begin
                        state <= BUSY;
                        count <= CW'(WIDTH);
                    end
                end
                BUSY: begin
                    count <= count - 1'b1;
                    if (count == CW'(1)) begin
                        state      <= DONE;
                        result_r   <= next_res;
                        negative_r <= next_res[WIDTH-1];
                        zero_r     <= (next_res == '0);
                    end
                end
                DONE: if (bus.out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Operand/working registers carry no reset; they are always loaded on accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_r <= bus.op;
            sa_r <= sa_in;
            sb_r <= sb_in;
            acc  <= is_div ? {{WIDTH{1'b0}}, abs_a} : '0;
            mc   <= {{WIDTH{1'b0}}, abs_a};
            mp   <= abs_b;
        end else if (state == BUSY) begin
            acc <= acc_nxt;
            mc  <= mc << 1;
            if (!op_r[2]) mp <= mp >> 1;
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = result_r;
    assign bus.negative  = negative_r;
    assign bus.zero      = zero_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised and directed checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
    localparam int W = 32;
    localparam logic [31:0] MINV = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    muldiv_if #(.WIDTH(W)) mif();
    muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .flush(flush), .bus(mif));

    always #5 clk = ~clk;

    function automatic logic [31:0] model_res(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, ub;
        logic [63:0] p;
        int ia, ib;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        ia = int'(a);
        ib = int'(b);
        r  = '0;
        p  = '0;
        case (o)
            3'd0: begin p = sa * sb; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF : (a == MINV && b == 32'hFFFF_FFFF) ? MINV : 32'(ia / ib);
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 0) ? a : (a == MINV && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(ia % ib);
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'd0;
            1: v = MINV;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'($urandom_range(1, 15));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Caller must be just after a negedge; returns just after the negedge following DONE exit.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input string tag);
        logic [31:0] exp_r;
        int exp_lat, lat;
        exp_r   = model_res(o, a, b);
        exp_lat = (o[2] && (b == 0 || (!o[0] && a == MINV && b == 32'hFFFF_FFFF))) ? 1 : W + 1;
        total_cnt++;
        if (mif.in_ready !== 1'b1) $display("FAIL %s in_ready before accept: got %b want 1", tag, mif.in_ready);
        else pass_cnt++;
        mif.in_valid = 1'b1; mif.op = o; mif.inputA = a; mif.inputB = b;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        mif.in_valid = 1'b0; mif.inputA = $urandom; mif.inputB = $urandom; mif.op = 3'($urandom);
        while (mif.out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        total_cnt++;
        if (lat !== exp_lat) $display("FAIL %s latency: got %0d want %0d", tag, lat, exp_lat);
        else pass_cnt++;
        total_cnt++;
        if (mif.result !== exp_r) $display("FAIL %s result: got %h want %h", tag, mif.result, exp_r);
        else pass_cnt++;
        total_cnt++;
        if (mif.negative !== exp_r[31] || mif.zero !== (exp_r == 0))
            $display("FAIL %s flags: got n=%b z=%b want n=%b z=%b", tag, mif.negative, mif.zero,
                     exp_r[31], exp_r == 0);
        else pass_cnt++;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            total_cnt++;
            if (mif.result !== exp_r || mif.out_valid !== 1'b1 || mif.in_ready !== 1'b0)
                $display("FAIL %s hold cycle %0d: got r=%h ov=%b ir=%b want r=%h ov=1 ir=0",
                         tag, i, mif.result, mif.out_valid, mif.in_ready, exp_r);
            else pass_cnt++;
        end
        mif.out_ready = 1'b1;
        @(negedge clk);
        mif.out_ready = 1'b0;
        total_cnt++;
        if (mif.out_valid !== 1'b0 || mif.in_ready !== 1'b1 || mif.result !== exp_r)
            $display("FAIL %s exit: got ov=%b ir=%b r=%h want ov=0 ir=1 r=%h",
                     tag, mif.out_valid, mif.in_ready, mif.result, exp_r);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0;
        mif.in_valid = 1'b0; mif.out_ready = 1'b0; mif.op = '0; mif.inputA = '0; mif.inputB = '0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (mif.in_ready !== 1'b1 || mif.out_valid !== 1'b0 || mif.result !== 32'd0 ||
            mif.negative !== 1'b0 || mif.zero !== 1'b0)
            $display("FAIL reset: got ir=%b ov=%b r=%h n=%b z=%b want 1 0 0 0 0",
                     mif.in_ready, mif.out_valid, mif.result, mif.negative, mif.zero);
        else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0, "mul_7x-3");
        do_op(3'd1, MINV, MINV, 0, "mulh_min");
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhu_max");
        do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 0, "mulhsu_-1x2");
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, "div_-7/2");
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0, "rem_-7,2");
        do_op(3'd5, 32'd100, 32'd7, 0, "divu_100/7");
        do_op(3'd7, 32'd100, 32'd7, 0, "remu_100,7");
        do_op(3'd5, 32'd5, 32'd0, 0, "divu_by0");
        do_op(3'd6, 32'd5, 32'd0, 0, "rem_by0");
        do_op(3'd4, MINV, 32'hFFFF_FFFF, 0, "div_ovf");
        do_op(3'd6, MINV, 32'hFFFF_FFFF, 0, "rem_ovf");
    endtask

    task automatic test_hold();
        do_op(3'd0, 32'd1234, 32'd5678, 10, "hold_mul");
    endtask

    task automatic test_back_to_back();
        do_op(3'd4, 32'd1000, 32'hFFFF_FFF6, 0, "b2b_first");
        do_op(3'd7, 32'hDEAD_BEEF, 32'd0, 0, "b2b_second");
        do_op(3'd1, 32'h1234_5678, 32'h8765_4321, 0, "b2b_third");
    endtask

    task automatic test_random();
        logic [2:0] o;
        logic [31:0] a, b;
        for (int n = 0; n < 60; n++) begin
            o = 3'($urandom_range(0, 7));
            a = pick_operand();
            b = pick_operand();
            do_op(o, a, b, $urandom_range(0, 2), $sformatf("rand%0d_op%0d", n, o));
        end
    endtask

    task automatic test_flush();
        logic [31:0] prev;
        bit seen;
        prev = mif.result;
        mif.in_valid = 1'b1; mif.op = 3'd0; mif.inputA = 32'd99; mif.inputB = 32'd77;
        @(posedge clk);
        @(negedge clk);
        mif.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        flush = 1'b1; mif.out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0; mif.out_ready = 1'b0;
        total_cnt++;
        if (mif.in_ready !== 1'b1 || mif.out_valid !== 1'b0 || mif.result !== prev)
            $display("FAIL flush_busy: got ir=%b ov=%b r=%h want ir=1 ov=0 r=%h",
                     mif.in_ready, mif.out_valid, mif.result, prev);
        else pass_cnt++;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mif.out_valid === 1'b1) seen = 1'b1;
        end
        total_cnt++;
        if (seen !== 1'b0) $display("FAIL flush_no_valid: got out_valid seen=%b want 0", seen);
        else pass_cnt++;
        do_op(3'd5, 32'd81, 32'd9, 0, "after_flush");
    endtask

    task automatic test_rst_mid();
        mif.in_valid = 1'b1; mif.op = 3'd1; mif.inputA = 32'h7FFF_0001; mif.inputB = 32'h0003_0002;
        @(posedge clk);
        @(negedge clk);
        mif.in_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        total_cnt++;
        if (mif.out_valid !== 1'b0 || mif.in_ready !== 1'b1 || mif.result !== 32'd0)
            $display("FAIL rst_busy: got ov=%b ir=%b r=%h want 0 1 0", mif.out_valid, mif.in_ready, mif.result);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mif.in_valid = 1'b1; mif.op = 3'd5; mif.inputA = 32'd3; mif.inputB = 32'd0;
        @(posedge clk);
        @(negedge clk);
        mif.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (mif.out_valid !== 1'b0 || mif.in_ready !== 1'b1 || mif.result !== 32'd0 || mif.zero !== 1'b0)
            $display("FAIL rst_done: got ov=%b ir=%b r=%h z=%b want 0 1 0 0",
                     mif.out_valid, mif.in_ready, mif.result, mif.zero);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_op(3'd3, 32'h0001_0000, 32'h0001_0000, 0, "after_rst");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_back_to_back();
        test_random();
        test_flush();
        test_rst_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
